// File: rtl/clarvi_slice_collector.sv
// rtl/clarvi_slice_collector.sv - reassembles eight byte slices into one 64-bit word
// Slices may arrive in any order; a completed word is held until the consumer takes it.
module clarvi_slice_collector #(
    parameter int SLICE_W   = 8,
    parameter int NUM_PARTS = 8
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [$clog2(NUM_PARTS)-1:0]   in_part_i,
    input  logic [SLICE_W-1:0]             in_data_i,
    input  logic [4:0]                     in_rd_i,
    input  logic                           in_is32_i,
    input  logic                           flush_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [SLICE_W*NUM_PARTS-1:0]   out_data_o,
    output logic [4:0]                     out_rd_o,
    output logic                           err_dup_o,
    output logic                           err_tag_o
);

    localparam int DATA_W = SLICE_W * NUM_PARTS;
    localparam int HALF_W = DATA_W / 2;
    localparam int IDX_W  = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_e;

    state_e                 state_q;
    logic [NUM_PARTS-1:0]   mask_q;
    logic [DATA_W-1:0]      data_q;
    logic [4:0]             rd_q;
    logic                   is32_q;
    logic                   out_valid_q;
    logic                   err_dup_q;
    logic                   err_tag_q;

    logic                   accept;
    logic [NUM_PARTS-1:0]   part_bit;
    logic [NUM_PARTS-1:0]   mask_d;
    logic [IDX_W-1:0]       base;

    assign in_ready_o = (state_q != FULL);
    // flush wins over acceptance, so a killed cycle never touches the word
    assign accept     = in_valid_i && in_ready_o && !flush_i;
    assign part_bit   = {{(NUM_PARTS-1){1'b0}}, 1'b1} << in_part_i;
    assign mask_d     = mask_q | part_bit;
    assign base       = IDX_W'(in_part_i) * IDX_W'(SLICE_W);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            data_q      <= '0;
            rd_q        <= '0;
            is32_q      <= 1'b0;
            out_valid_q <= 1'b0;
            err_dup_q   <= 1'b0;
            err_tag_q   <= 1'b0;
        end else begin
            err_dup_q <= 1'b0;
            err_tag_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rd_q                    <= in_rd_i;
                        is32_q                  <= in_is32_i;
                        mask_q                  <= part_bit;
                        data_q[base +: SLICE_W] <= in_data_i;
                        state_q                 <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (flush_i) begin
                        mask_q  <= '0;
                        state_q <= IDLE;
                    end else if (accept) begin
                        // a foreign tag is rejected before the duplicate check
                        if (in_rd_i != rd_q) begin
                            err_tag_q <= 1'b1;
                        end else if (mask_q[in_part_i]) begin
                            err_dup_q <= 1'b1;
                        end else begin
                            mask_q                  <= mask_d;
                            data_q[base +: SLICE_W] <= in_data_i;
                            if (mask_d == '1) begin
                                state_q     <= FULL;
                                out_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                FULL: begin
                    if (out_ready_i) begin
                        mask_q      <= '0;
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    mask_q      <= '0;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_rd_o    = rd_q;
    assign err_dup_o   = err_dup_q;
    assign err_tag_o   = err_tag_q;
    assign out_data_o  = is32_q ? {{HALF_W{data_q[HALF_W-1]}}, data_q[HALF_W-1:0]} : data_q;

endmodule
